key_event_responder: RTL and testbench

- Memory-mapped bus responder that turns raw push-button inputs into a queue of debounced press/release events the processor can read.
- Sits on the shared processor data bus beside the other memory-mapped input and output devices; uses the same address, write-enable and tri-state data bus.
- Software polls STATUS, reads the head event from DATA, then pops it by writing CTRL.

---
 rtl/key_event_responder_if.sv | 11 +
 rtl/key_event_responder.sv | 192 +++++++++++++++++++
 tb/tb_key_event_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_responder_if.sv
// Bus-side strobe and address for the key event responder.
// The shared tri-state data bus stays a plain inout port on the responder.
interface key_event_responder_if #(
  parameter int DBITS = 32
);
  logic             wrEn;
  logic [DBITS-1:0] addr;

  modport master (output wrEn, output addr);
  modport slave  (input  wrEn, input  addr);
endinterface

// File: rtl/key_event_responder.sv
// Memory-mapped push-button event queue: sync, debounce, press/release events into a FIFO.
// Optional KEYEVT_TIMESTAMP_EN stamps each entry with a prescaled 16-bit cycle counter.
module key_event_responder_lane #(
  parameter int          DW   = 16,
  parameter logic [DW-1:0] LAST = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_i,
  output logic db_o
);
  logic [DW-1:0] cnt_q;
  logic          db_q;

  // Any return to the accepted level restarts the stability count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else if (sync_i == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
      db_q  <= ~db_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign db_o = db_q;
endmodule

module key_event_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'hF000_0020,
  parameter int          DBITS           = 32,
  parameter int          KEYS            = 4,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          DEPTH           = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  key_event_responder_if.slave   bus,
  inout  wire  [DBITS-1:0]       dataBus,
  input  logic [KEYS-1:0]        keysIn
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [DW-1:0]    DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBITS-1:0] A_DATA  = DBITS'(BASE_ADDR);
  localparam logic [DBITS-1:0] A_STAT  = DBITS'(BASE_ADDR + 32'd4);
  localparam logic [DBITS-1:0] A_CTRL  = DBITS'(BASE_ADDR + 32'd8);

  logic [KEYS-1:0]  s1_q, sync_q, rep_q;
  logic [KEYS-1:0]  db;
  logic [KEYS-1:0]  evt_oh;
  logic [3:0]       evt_idx;
  logic             evt_vld, evt_lvl;
  logic [15:0]      ts;
  logic [DBITS-1:0] ent, rdata;
  logic [DBITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             empty, full, wr_ctrl, clr, pop, push, drop, hit, drive;
  logic             unused_wd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      sync_q <= '0;
    end else begin
      s1_q   <= keysIn;
      sync_q <= s1_q;
    end
  end

  for (genvar g = 0; g < KEYS; g++) begin : g_lane
    key_event_responder_lane #(.DW(DW), .LAST(DB_LAST)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .sync_i (sync_q[g]),
      .db_o   (db[g])
    );
  end

  // Lowest-index key whose debounced level differs from what was last reported.
  always_comb begin
    evt_oh  = '0;
    evt_idx = '0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (db[i] != rep_q[i]) begin
        evt_oh    = '0;
        evt_oh[i] = 1'b1;
        evt_idx   = 4'(i);
      end
    end
  end
  assign evt_vld = |evt_oh;
  assign evt_lvl = |(db & evt_oh);

`ifdef KEYEVT_TIMESTAMP_EN
  logic [9:0]  pre_q;
  logic [15:0] ts_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
      ts_q  <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
      if (&pre_q) ts_q <= ts_q + 1'b1;
    end
  end
  assign ts = ts_q;
`else
  assign ts = '0;
`endif

  always_comb begin
    ent       = '0;
    ent[31]   = 1'b1;
    ent[23:8] = ts;
    ent[4]    = evt_lvl;
    ent[3:0]  = evt_idx;
  end

  assign wr_ctrl   = bus.wrEn && (bus.addr == A_CTRL);
  assign clr       = wr_ctrl & dataBus[1];
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == DEPTH_C);
  // Clear swallows the pending event; a pop on an empty queue is a no-op.
  assign pop       = wr_ctrl & dataBus[0] & ~empty & ~clr;
  assign push      = evt_vld & ~clr & (~full | pop);
  assign drop      = evt_vld & ~clr & ~push;
  assign unused_wd = ^dataBus[DBITS-1:3];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
    ovf_d = ovf_q;
    if (drop)                         ovf_d = 1'b1;
    else if (wr_ctrl && dataBus[2])   ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      rep_q <= rep_q ^ evt_oh;
      ovf_q <= ovf_d;
      if (clr) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        cnt_q <= cnt_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= ent;
  end

  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    case (bus.addr)
      A_DATA: rdata = empty ? '0 : mem_q[rptr_q];
      A_STAT: begin
        rdata[7:0]   = 8'(cnt_q);
        rdata[8]     = empty;
        rdata[9]     = full;
        rdata[10]    = ovf_q;
        rdata[31:16] = 16'(db);
      end
      A_CTRL:  rdata = '0;
      default: hit   = 1'b0;
    endcase
  end

  assign drive   = reset & ~bus.wrEn & hit;
  assign dataBus = drive ? rdata : 'z;
endmodule

// File: tb/tb_key_event_responder.sv
// Directed plus randomized checks of the key event responder against an event-level queue model.
module tb_key_event_responder;
  localparam int          KEYS  = 4;
  localparam int          DEPTH = 8;
  localparam int          DC    = 4;
  localparam int          HOLD  = 16;
  localparam logic [31:0] BASE  = 32'hF000_0020;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;
  localparam logic [31:0] A_CTRL = BASE + 32'd8;
  localparam logic [31:0] A_NONE = BASE + 32'd12;
`ifdef KEYEVT_TIMESTAMP_EN
  localparam logic [31:0] DMASK = 32'hFF00_00FF;
`else
  localparam logic [31:0] DMASK = 32'hFFFF_FFFF;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [KEYS-1:0] keys;
  logic            tb_oe;
  logic [31:0]     tb_wd;
  wire  [31:0]     dataBus;

  logic [31:0] mq[$];
  logic        mov;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] v;

  pullup (dataBus);
  assign dataBus = tb_oe ? tb_wd : 'z;

  key_event_responder_if #(.DBITS(32)) bus_if ();

  key_event_responder #(
    .BASE_ADDR(BASE), .DBITS(32), .KEYS(KEYS), .DEBOUNCE_CYCLES(DC), .DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .dataBus (dataBus),
    .keysIn  (keys)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: got %08h want %08h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] m_ent(input int i, input logic lvl);
    return 32'h8000_0000 + (lvl ? 32'h10 : 32'h0) + 32'(i);
  endfunction

  function automatic void m_push(input logic [31:0] e);
    if (mq.size() < DEPTH) mq.push_back(e);
    else mov = 1'b1;
  endfunction

  function automatic void m_ctrl(input logic [2:0] c);
    if (c[1]) mq.delete();
    else if (c[0] && mq.size() > 0) void'(mq.pop_front());
    if (c[2]) mov = 1'b0;
  endfunction

  task automatic rd_now(input logic [31:0] a, output logic [31:0] d);
    bus_if.addr = a;
    bus_if.wrEn = 1'b0;
    #1 d = dataBus;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    rd_now(a, d);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.addr = a; tb_wd = d; tb_oe = 1'b1; bus_if.wrEn = 1'b1;
    @(negedge clk);
    bus_if.wrEn = 1'b0; tb_oe = 1'b0; bus_if.addr = '0;
  endtask

  task automatic settle();
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic set_keys(input logic [KEYS-1:0] nk);
    @(negedge clk);
    for (int i = 0; i < KEYS; i++)
      if (nk[i] != keys[i]) m_push(m_ent(i, nk[i]));
    keys = nk;
    settle();
  endtask

  task automatic glitch(input logic [KEYS-1:0] mask, input int len);
    @(negedge clk);
    keys = keys ^ mask;
    repeat (len) @(negedge clk);
    keys = keys ^ mask;
    settle();
  endtask

  task automatic ctrl(input logic [2:0] c);
    wr(A_CTRL, 32'(c));
    m_ctrl(c);
  endtask

  // Single-key toggle whose event reaches the queue on the same edge as a CTRL write.
  task automatic race(input int k, input logic [2:0] c);
    logic [KEYS-1:0] nk;
    nk = keys ^ (KEYS'(1) << k);
    @(negedge clk);
    keys = nk;
    repeat (DC + 2) @(posedge clk);
    @(negedge clk);
    bus_if.addr = A_CTRL; tb_wd = 32'(c); tb_oe = 1'b1; bus_if.wrEn = 1'b1;
    @(negedge clk);
    bus_if.wrEn = 1'b0; tb_oe = 1'b0; bus_if.addr = '0;
    if (c[2]) mov = 1'b0;
    if (c[1]) mq.delete();
    else begin
      if (c[0] && mq.size() > 0) void'(mq.pop_front());
      m_push(m_ent(k, nk[k]));
    end
    settle();
  endtask

  task automatic check(input string tag);
    logic [31:0] want;
    want = 32'(mq.size()) | (mq.size() == 0 ? 32'h100 : 32'h0)
         | (mq.size() == DEPTH ? 32'h200 : 32'h0) | (mov ? 32'h400 : 32'h0)
         | (32'(keys) << 16);
    rd(A_STAT, v);
    chk({tag, "/status"}, v, want);
    rd(A_DATA, v);
    chk({tag, "/data"}, v & DMASK, (mq.size() > 0 ? mq[0] : 32'h0) & DMASK);
  endtask

  initial begin
    reset = 1'b0; keys = '0; tb_oe = 1'b0; tb_wd = '0;
    bus_if.wrEn = 1'b0; bus_if.addr = '0; mov = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    check("reset");
    rd(A_CTRL, v);  chk("ctrl_read", v, 32'h0);
    rd(A_NONE, v);  chk("hiz_addr", v, 32'hFFFF_FFFF);

    set_keys(4'b0100);
    check("accept");
    rd(A_DATA, v);  chk("accept_entry", v & DMASK, 32'h8000_0012 & DMASK);
    set_keys(4'b0000);
    check("release");
    ctrl(3'd1); ctrl(3'd1);
    check("pop2");

    glitch(4'b0010, DC - 1);
    check("reject");

    set_keys(4'b1001);
    check("simul");
    ctrl(3'd1);
    check("simul_pop1");
    ctrl(3'd1);
    check("simul_empty");
    set_keys(4'b0000);
    wr(A_DATA, 32'h7); wr(A_STAT, 32'h7);
    check("ignored_wr");
    ctrl(3'd2);
    check("clear");

    set_keys(4'b0001); set_keys(4'b0011); set_keys(4'b0111);
    set_keys(4'b1111); set_keys(4'b1110); set_keys(4'b1100);
    set_keys(4'b1000); set_keys(4'b0000); set_keys(4'b0001);
    check("overflow");
    ctrl(3'd4);
    check("ovf_clear");

    race(2, 3'd1);
    check("full_push_pop");
    race(2, 3'd4);
    check("ovf_set_beats_clr");
    ctrl(3'd4);
    race(0, 3'd2);
    check("clear_race");
    race(3, 3'd1);
    check("empty_push_pop");

    ctrl(3'd6);
    set_keys(4'b0000); ctrl(3'd2);
    set_keys(4'b0010); set_keys(4'b0011); set_keys(4'b0010);
    check("pre_reset");
    @(negedge clk);
    #1 reset = 1'b0;
    rd_now(A_STAT, v); chk("reset_hiz", v, 32'hFFFF_FFFF);
    #1 reset = 1'b1;
    rd_now(A_STAT, v); chk("reset_async", v, 32'h0000_0100);
    mq.delete(); mov = 1'b0;
    for (int i = 0; i < KEYS; i++)
      if (keys[i]) m_push(m_ent(i, 1'b1));
    settle();
    check("held_press");

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: set_keys(keys ^ KEYS'($urandom_range(1, 15)));
        4:          glitch(KEYS'($urandom_range(1, 15)), int'($urandom_range(1, DC - 1)));
        5, 6:       ctrl(3'd1);
        7:          ctrl(3'($urandom_range(0, 7)));
        8:          wr(($urandom_range(0, 1) == 1) ? A_DATA : A_STAT, $urandom);
        default:    race(int'($urandom_range(0, KEYS - 1)), 3'($urandom_range(0, 7)));
      endcase
      check("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
